// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron predictor training path.
// Weight rows are packed with w[i] at bits [i*WIDTH +: WIDTH].
package perceptron_pkg;

    localparam int N     = 62;
    localparam int WIDTH = 8;
    localparam int INDEX = 6;
    localparam int YW    = WIDTH + $clog2(N) + 1;
    localparam int THETA = 131;

    typedef logic signed [WIDTH-1:0] weight_t;
    typedef logic [N-1:0][WIDTH-1:0] row_t;

    typedef struct packed {
        logic [INDEX-1:0]     idx;
        logic [N-2:0]         hist;
        logic signed [YW-1:0] y;
        logic                 taken;
    } train_req_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CALC,
        WRITE
    } train_state_e;

    // Adding +/-1 to an in-range weight overflows only when the top two bits differ.
    function automatic weight_t sat_add(input weight_t w, input logic up);
        logic signed [WIDTH:0] d;
        logic signed [WIDTH:0] s;
        d = up ? (WIDTH+1)'(1) : '1;
        s = $signed({w[WIDTH-1], w}) + d;
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        return s[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/perceptron_train_ctrl_fifo.sv
// Request FIFO holding resolved-branch training requests.
// A push while full is dropped; the producer must honour full.
module train_fifo
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  train_req_t wdata,
    input  logic       pop,
    output train_req_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    train_req_t     mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    count;
    logic           wr;
    logic           rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            if (rd)
                rptr <= rptr + AW'(1);
            unique case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron weight-table training controller: queue, decide, read,
// saturate-update and write back, yielding the index port to lookups.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 train_valid,
    output logic                 train_ready,
    input  logic [INDEX-1:0]     train_idx,
    input  logic [N-2:0]         train_hist,
    input  logic signed [YW-1:0] train_y,
    input  logic                 train_taken,
    input  logic                 pred_req,
    input  logic [INDEX-1:0]     pred_idx,
    output logic [INDEX-1:0]     tbl_idx,
    input  logic [N*WIDTH-1:0]   tbl_rdata,
    output logic                 tbl_we,
    output logic [N*WIDTH-1:0]   tbl_wdata,
    output logic                 busy,
    output logic [15:0]          train_cnt
);

    train_state_e state_q;
    train_state_e state_d;
    train_req_t   push_req;
    train_req_t   head;
    logic         full;
    logic         empty;
    logic         pop;
    logic         need;
    logic         latch;

    logic [INDEX-1:0]     idx_q;
    logic [N-2:0]         hist_q;
    logic                 taken_q;
    row_t                 row_q;
    row_t                 wdata_q;
    row_t                 new_row;
    logic [15:0]          cnt_q;
    logic signed [YW:0]   y_ext;
    logic signed [YW:0]   y_abs;

    assign push_req = '{idx: train_idx, hist: train_hist,
                        y: train_y, taken: train_taken};

    train_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (train_valid),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // One extra bit keeps |most-negative y| representable.
    assign y_ext = {head.y[YW-1], head.y};
    assign y_abs = y_ext[YW] ? -y_ext : y_ext;
    assign need  = (head.y[YW-1] == head.taken)
                || (y_abs <= (YW+1)'(THETA));
    assign latch = (state_q == IDLE) && !empty && need;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (need)
                        state_d = READ;
                end
            end
            READ:    if (!pred_req) state_d = CALC;
            CALC:    state_d = WRITE;
            WRITE:   if (!pred_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tbl_idx = pred_req ? pred_idx : idx_q;
        tbl_we  = (state_q == WRITE) && !pred_req;
    end

    always_comb begin
        new_row    = '0;
        new_row[0] = sat_add(row_q[0], taken_q);
        for (int i = 1; i < N; i++)
            new_row[i] = sat_add(row_q[i], hist_q[i-1] ~^ taken_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            hist_q  <= '0;
            taken_q <= 1'b0;
            row_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (latch) begin
                idx_q   <= head.idx;
                hist_q  <= head.hist;
                taken_q <= head.taken;
            end
            if (state_q == READ && !pred_req)
                row_q <= tbl_rdata;
            if (state_q == CALC)
                wdata_q <= new_row;
            if (tbl_we)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign train_ready = !full;
    assign busy        = (state_q != IDLE) || !empty;
    assign tbl_wdata   = wdata_q;
    assign train_cnt   = cnt_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed and randomized bench for perceptron_train_ctrl against a
// request-level model of the training rule and weight table.
module tb_perceptron_train_ctrl;

    localparam int N  = 62;
    localparam int W  = 8;
    localparam int IW = 6;
    localparam int YW = 15;
    localparam int TH = 131;
    localparam int RW = N * W;

    typedef struct {
        int           idx;
        logic [N-2:0] hist;
        int           y;
        bit           taken;
    } req_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 train_valid = 1'b0;
    logic                 train_ready;
    logic [IW-1:0]        train_idx = '0;
    logic [N-2:0]         train_hist = '0;
    logic signed [YW-1:0] train_y = '0;
    logic                 train_taken = 1'b0;
    logic                 pred_req = 1'b0;
    logic [IW-1:0]        pred_idx = '0;
    logic [IW-1:0]        tbl_idx;
    logic [RW-1:0]        tbl_rdata;
    logic                 tbl_we;
    logic [RW-1:0]        tbl_wdata;
    logic                 busy;
    logic [15:0]          train_cnt;

    logic [RW-1:0] tbl  [64];
    logic [RW-1:0] mtbl [64];
    req_t          pend [$];
    int            passed = 0;
    int            total = 0;
    int            exp_cnt = 0;
    req_t          mr;
    logic [RW-1:0] me;

    perceptron_train_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .train_valid (train_valid),
        .train_ready (train_ready),
        .train_idx   (train_idx),
        .train_hist  (train_hist),
        .train_y     (train_y),
        .train_taken (train_taken),
        .pred_req    (pred_req),
        .pred_idx    (pred_idx),
        .tbl_idx     (tbl_idx),
        .tbl_rdata   (tbl_rdata),
        .tbl_we      (tbl_we),
        .tbl_wdata   (tbl_wdata),
        .busy        (busy),
        .train_cnt   (train_cnt)
    );

    always #5 clk = ~clk;

    assign tbl_rdata = tbl[tbl_idx];

    always @(posedge clk)
        if (tbl_we)
            tbl[tbl_idx] <= tbl_wdata;

    task automatic check(input string tag, input logic [RW-1:0] obs,
                         input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit need_f(int y, bit taken);
        int a;
        a = (y < 0) ? -y : y;
        return ((y >= 0) != taken) || (a <= TH);
    endfunction

    function automatic logic [RW-1:0] upd(logic [RW-1:0] row, req_t r);
        logic [RW-1:0] o;
        int w;
        int x;
        int v;
        o = '0;
        for (int i = 0; i < N; i++) begin
            w = $signed(row[i*W +: W]);
            x = (i == 0) ? 1 : (r.hist[i-1] ? 1 : -1);
            v = w + (r.taken ? x : -x);
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            o[i*W +: W] = v[W-1:0];
        end
        return o;
    endfunction

    function automatic logic [N-2:0] rand_hist();
        logic [63:0] h;
        h = {$urandom(), $urandom()};
        return h[N-2:0];
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] o;
        logic [31:0] u;
        for (int i = 0; i < N; i++) begin
            u = $urandom();
            o[i*W +: W] = u[W-1:0];
        end
        return o;
    endfunction

    function automatic req_t mk(int idx, int y, bit taken, logic [N-2:0] h);
        req_t r;
        r.idx = idx;
        r.y = y;
        r.taken = taken;
        r.hist = h;
        return r;
    endfunction

    // Expected write order and contents: requests needing training, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pred_req)
                check("arb_idx", tbl_idx, pred_idx);
            if (tbl_we) begin
                check("we_vs_pred", pred_req, 0);
                if (pend.size() == 0) begin
                    check("unexpected_we", tbl_we, 0);
                end else begin
                    mr = pend.pop_front();
                    me = upd(mtbl[mr.idx], mr);
                    check("wr_idx", tbl_idx, mr.idx);
                    check("wr_data", tbl_wdata, me);
                    mtbl[mr.idx] = me;
                    exp_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit v, input req_t r, output bit acc);
        logic [31:0] yv;
        yv = r.y;
        train_valid = v;
        train_idx = r.idx[IW-1:0];
        train_hist = r.hist;
        train_y = yv[YW-1:0];
        train_taken = r.taken;
        @(negedge clk);
        acc = v && train_ready;
        if (acc && need_f(r.y, r.taken))
            pend.push_back(r);
        step();
        train_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        req_t r;
        bit acc;
        logic [N-2:0] h;
        int ys [7];
        bit ts [7];
        bit ns [7];

        for (int i = 0; i < 64; i++) begin
            tbl[i] = '0;
            mtbl[i] = '0;
        end

        // Reset values, index port follows lookups during reset.
        rst_n = 1'b0;
        pred_req = 1'b1;
        pred_idx = 6'd7;
        step();
        step();
        @(negedge clk);
        check("rst_ready", train_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_we", tbl_we, 0);
        check("rst_wdata", tbl_wdata, 0);
        check("rst_cnt", train_cnt, 0);
        check("rst_idx_pred", tbl_idx, 7);
        pred_req = 1'b0;
        #1;
        check("rst_idx", tbl_idx, 0);
        step();
        rst_n = 1'b1;
        step();

        // Basic training with exact 4-cycle latency.
        r = mk(5, 20, 1'b1, rand_hist());
        cyc(1'b1, r, acc);
        check("t1_acc", acc, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_lat", tbl_we, 0);
        end
        @(negedge clk);
        check("t1_we", tbl_we, 1);
        check("t1_idx", tbl_idx, 5);
        check("t1_w0", tbl_wdata[7:0], 8'h01);
        wait_idle();
        check("t1_cnt", train_cnt, 1);

        // Decision boundaries: skipped requests pop in one cycle.
        ys = '{200, -16384, -131, 131, 132, -5, 16383};
        ts = '{1, 0, 0, 1, 1, 1, 0};
        ns = '{0, 0, 1, 1, 0, 1, 1};
        for (int k = 0; k < 7; k++) begin
            r = mk(8, ys[k], ts[k], rand_hist());
            cyc(1'b1, r, acc);
            @(negedge clk);
            check("t2_busy_head", busy, 1);
            @(negedge clk);
            check("t2_need", busy, ns[k]);
            step();
            wait_idle();
        end
        check("t2_cnt", train_cnt, exp_cnt);

        // Saturation at both ends.
        tbl[3] = rand_row();
        tbl[3][7:0] = 8'h7f;
        tbl[3][15:8] = 8'h80;
        mtbl[3] = tbl[3];
        h = rand_hist();
        h[0] = 1'b0;
        r = mk(3, 10, 1'b1, h);
        cyc(1'b1, r, acc);
        wait_idle();
        check("t3_w0", tbl[3][7:0], 8'h7f);
        check("t3_w1", tbl[3][15:8], 8'h80);

        // Lookup stall during READ: no capture of the lookup row.
        tbl[11] = rand_row();
        mtbl[11] = tbl[11];
        tbl[9] = rand_row();
        mtbl[9] = tbl[9];
        r = mk(11, -50, 1'b0, rand_hist());
        cyc(1'b1, r, acc);
        pred_req = 1'b1;
        pred_idx = 6'd9;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t4_idx", tbl_idx, 9);
            check("t4_we", tbl_we, 0);
            check("t4_busy", busy, 1);
        end
        step();
        pred_req = 1'b0;
        wait_idle();
        check("t4_cnt", train_cnt, exp_cnt);

        // Fill the FIFO while a request is in flight.
        r = mk(12, 1, 1'b1, rand_hist());
        cyc(1'b1, r, acc);
        for (int k = 0; k < 4; k++) begin
            r = mk(12 + k % 2, $urandom_range(0, 200) - 100,
                   1'($urandom_range(0, 1)), rand_hist());
            cyc(1'b1, r, acc);
            check("t5_acc", acc, 1);
        end
        r = mk(12, -7, 1'b1, rand_hist());
        cyc(1'b1, r, acc);
        check("t5_full_ready", acc, 0);
        cyc(1'b1, r, acc);
        check("t5_after_pop", acc, 1);
        wait_idle();
        check("t5_cnt", train_cnt, exp_cnt);
        check("t5_drained", pend.size(), 0);

        // Randomized traffic with contended lookups and same-row hazards.
        for (int k = 0; k < 60; k++) begin
            int y;
            y = int'($urandom_range(0, 600)) - 300;
            if ($urandom_range(0, 9) == 0)
                y = ($urandom_range(0, 1) == 1) ? 16383 : -16384;
            pred_req = ($urandom_range(0, 2) == 0);
            pred_idx = 6'($urandom_range(0, 63));
            r = mk($urandom_range(0, 3), y, 1'($urandom_range(0, 1)),
                   rand_hist());
            cyc(1'($urandom_range(0, 1)), r, acc);
        end
        pred_req = 1'b0;
        wait_idle();
        check("rnd_cnt", train_cnt, exp_cnt);
        check("rnd_drained", pend.size(), 0);

        // Reset while in CALC drops the request.
        mtbl[20] = tbl[20];
        r = mk(20, 0, 1'b1, rand_hist());
        cyc(1'b1, r, acc);
        for (int k = 0; k < 3; k++)
            @(negedge clk);
        rst_n = 1'b0;
        pend.delete();
        exp_cnt = 0;
        step();
        @(negedge clk);
        check("t6_we", tbl_we, 0);
        check("t6_busy", busy, 0);
        check("t6_cnt", train_cnt, 0);
        check("t6_ready", train_ready, 1);
        check("t6_row", tbl[20], mtbl[20]);
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
